// File: rtl/video_pkg.sv
// Shared types and constants for the AXI4-Stream video pattern source.
// Pattern and FSM encodings plus the LFSR seed and step function.
package video_pkg;

    typedef enum logic [1:0] {
        GRADIENT = 2'd0,
        CONST    = 2'd1,
        CHECKER  = 2'd2,
        LFSR     = 2'd3
    } pattern_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci taps 16,14,13,11 expressed as bits 15,13,12,10.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load and step enable.
// Load has priority so a frame restart always reseeds cleanly.
module lfsr16
    import video_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Next value: reseed, step, or hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = LFSR_SEED;
        end else if (advance) begin
            q_d = lfsr_next(q_q);
        end
    end

    // Shift register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream raster source: gradient, constant, checkerboard or LFSR.
// tuser flags frame start, tlast flags end of line; outputs fully registered.
module axis_video_pattern_gen
    import video_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 20,
    parameter int FRAME_HEIGHT = 20,
    parameter int H_BLANK      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] const_value,
    output logic                  busy,
    output logic                  frame_done,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready
);

    localparam int CW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
    localparam logic [7:0] BLANK_INIT = 8'((H_BLANK > 0) ? H_BLANK - 1 : 0);

    state_e                state_q, state_d;
    pattern_mode_e         mode_q, mode_d;
    logic [DATA_WIDTH-1:0] const_q, const_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [7:0]            blank_q, blank_d;
    logic                  tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [15:0]           lfsr_q;
    logic                  lfsr_load;
    logic                  lfsr_adv;

    logic                  hs;
    logic                  last_col;
    logic                  last_row;
    logic [CW-1:0]         nx_col;
    logic [RW-1:0]         nx_row;

    pattern_mode_e         sel_mode;
    logic [RW-1:0]         sel_row;
    logic [CW-1:0]         sel_col;
    logic [DATA_WIDTH-1:0] sel_const;
    logic [DATA_WIDTH-1:0] sel_lfsr;
    logic                  frame_start;
    logic                  load_px;

    function automatic logic [DATA_WIDTH-1:0] pixel_of(
        input pattern_mode_e         m,
        input logic [RW-1:0]         r,
        input logic [CW-1:0]         c,
        input logic [DATA_WIDTH-1:0] cv,
        input logic [DATA_WIDTH-1:0] lf
    );
        case (m)
            GRADIENT: return DATA_WIDTH'(32'(r) + 32'(c));
            CONST:    return cv;
            CHECKER:  return {DATA_WIDTH{r[0] ^ c[0]}};
            default:  return lf;
        endcase
    endfunction

    lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .q       (lfsr_q)
    );

    assign hs       = tvalid_q & m_axis_tready;
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);
    assign nx_col   = last_col ? '0 : col_q + 1'b1;
    assign nx_row   = last_col ? row_q + 1'b1 : row_q;

    // FSM next state, raster advance and next-pixel selection.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        const_d     = const_q;
        col_d       = col_q;
        row_d       = row_q;
        blank_d     = blank_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;
        frame_start = 1'b0;
        load_px     = 1'b0;
        sel_mode    = mode_q;
        sel_row     = nx_row;
        sel_col     = nx_col;
        sel_const   = const_q;
        sel_lfsr    = DATA_WIDTH'(lfsr_next(lfsr_q));

        case (state_q)
            IDLE: begin
                if (start) begin
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (hs) begin
                    if (last_col && last_row) begin
                        done_d = 1'b1;
                        if (continuous) begin
                            frame_start = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            tvalid_d = 1'b0;
                            busy_d   = 1'b0;
                        end
                    end else begin
                        lfsr_adv = 1'b1;
                        col_d    = nx_col;
                        row_d    = nx_row;
                        load_px  = 1'b1;
                        // Next pixel is staged now and released after the gap.
                        if (last_col && (H_BLANK > 0)) begin
                            state_d  = HBLANK;
                            tvalid_d = 1'b0;
                            blank_d  = BLANK_INIT;
                        end
                    end
                end
            end
            HBLANK: begin
                if (blank_q == 8'd0) begin
                    state_d  = ACTIVE;
                    tvalid_d = 1'b1;
                end else begin
                    blank_d = blank_q - 8'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

        // Frame start latches the pattern and presents pixel (0,0).
        if (frame_start) begin
            state_d   = ACTIVE;
            mode_d    = pattern_mode_e'(mode);
            const_d   = const_value;
            col_d     = '0;
            row_d     = '0;
            tvalid_d  = 1'b1;
            busy_d    = 1'b1;
            lfsr_load = 1'b1;
            load_px   = 1'b1;
            sel_mode  = pattern_mode_e'(mode);
            sel_row   = '0;
            sel_col   = '0;
            sel_const = const_value;
            sel_lfsr  = DATA_WIDTH'(LFSR_SEED);
        end

        if (load_px) begin
            tdata_d = pixel_of(sel_mode, sel_row, sel_col,
                               sel_const, sel_lfsr);
            tlast_d = (sel_col == COL_LAST);
            tuser_d = (sel_row == '0) && (sel_col == '0);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= GRADIENT;
            const_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            blank_q  <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            const_q  <= const_d;
            col_q    <= col_d;
            row_q    <= row_d;
            blank_q  <= blank_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Self-checking bench for axis_video_pattern_gen.
// Scoreboard of expected beats, compared on each handshake at negedge.
module tb_axis_video_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start_hb = 1'b0;
    logic       continuous = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] const_value = 8'h00;
    logic       tready = 1'b1;
    logic       tready_hb = 1'b1;

    logic       busy, done, tvalid, tlast, tuser;
    logic [7:0] tdata;
    logic       busy_hb, done_hb, tvalid_hb, tlast_hb, tuser_hb;
    logic [7:0] tdata_hb;

    int vectors = 0;
    int errors  = 0;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    axis_video_pattern_gen #(
        .DATA_WIDTH(8), .FRAME_WIDTH(20), .FRAME_HEIGHT(20), .H_BLANK(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .mode(mode), .const_value(const_value), .busy(busy),
        .frame_done(done), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tlast(tlast), .m_axis_tuser(tuser), .m_axis_tready(tready)
    );

    axis_video_pattern_gen #(
        .DATA_WIDTH(8), .FRAME_WIDTH(20), .FRAME_HEIGHT(20), .H_BLANK(3)
    ) dut_hb (
        .clk(clk), .rst(rst), .start(start_hb), .continuous(continuous),
        .mode(mode), .const_value(const_value), .busy(busy_hb),
        .frame_done(done_hb), .m_axis_tdata(tdata_hb),
        .m_axis_tvalid(tvalid_hb), .m_axis_tlast(tlast_hb),
        .m_axis_tuser(tuser_hb), .m_axis_tready(tready_hb)
    );

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [9:0] grad_beat(input int k);
        logic [7:0] d;
        d = 8'((k / 20) + (k % 20));
        return {k == 0, (k % 20) == 19, d};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({tvalid, tlast, tuser, busy, done} !== 5'b0 || tdata !== 8'h00) begin
            errors++;
            $display("FAIL reset: got v%b l%b u%b b%b d%b data %h, want all 0",
                     tvalid, tlast, tuser, busy, done, tdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_gradient(input bit rnd);
        logic [9:0] exp, held;
        bit stall = 0;
        int dones = 0;
        int cyc = 0;
        sb.delete();
        for (int k = 0; k < 400; k++) sb.push_back(grad_beat(k));
        mode = 2'd0; continuous = 1'b0; start = 1'b1;
        tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (tvalid !== 1'b1 || tuser !== 1'b1) begin
            errors++;
            $display("FAIL grad_latency: tvalid %b tuser %b, want 1 1", tvalid, tuser);
        end
        while (sb.size() > 0 && cyc < 5000) begin
            if (stall) begin
                vectors++;
                if (tvalid !== 1'b1 || {tuser, tlast, tdata} !== held) begin
                    errors++;
                    $display("FAIL grad_stable: v%b beat %h, want v1 beat %h",
                             tvalid, {tuser, tlast, tdata}, held);
                end
            end
            if (done === 1'b1) dones++;
            if (tvalid && tready) begin
                exp = sb.pop_front();
                vectors++;
                if ({tuser, tlast, tdata} !== exp) begin
                    errors++;
                    $display("FAIL grad_beat %0d: got %h want %h",
                             399 - sb.size(), {tuser, tlast, tdata}, exp);
                end
                stall = 0;
            end else begin
                stall = tvalid;
                held = {tuser, tlast, tdata};
            end
            @(negedge clk);
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        if (sb.size() > 0) begin
            vectors++; errors++;
            $display("FAIL grad_timeout: %0d beats left, want 0", sb.size());
        end
        tready = 1'b1;
        repeat (3) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        vectors++;
        if (dones != 1 || busy !== 1'b0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL grad_end: done pulses %0d busy %b tvalid %b, want 1 0 0",
                     dones, busy, tvalid);
        end
    endtask

    task automatic test_hblank();
        int gap[20];
        int beats = 0, span = 0, cyc = 0;
        logic [9:0] exp;
        for (int i = 0; i < 20; i++) gap[i] = 0;
        mode = 2'd0; continuous = 1'b0; tready_hb = 1'b1; start_hb = 1'b1;
        @(negedge clk);
        start_hb = 1'b0;
        while (beats < 400 && cyc < 2000) begin
            if (tvalid_hb) begin
                exp = grad_beat(beats);
                vectors++;
                if ({tuser_hb, tlast_hb, tdata_hb} !== exp) begin
                    errors++;
                    $display("FAIL hb_beat %0d: got %h want %h",
                             beats, {tuser_hb, tlast_hb, tdata_hb}, exp);
                end
                beats++;
                span++;
            end else if (beats > 0) begin
                gap[(beats - 1) / 20]++;
                span++;
            end
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 19; i++) begin
            vectors++;
            if (gap[i] != 3) begin
                errors++;
                $display("FAIL hb_gap line %0d: got %0d want 3", i, gap[i]);
            end
        end
        vectors++;
        if (span != 457) begin
            errors++;
            $display("FAIL hb_span: got %0d cycles want 457", span);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (tvalid_hb !== 1'b0 || busy_hb !== 1'b0) begin
            errors++;
            $display("FAIL hb_end: tvalid %b busy %b, want 0 0", tvalid_hb, busy_hb);
        end
    endtask

    task automatic test_patterns();
        logic [9:0] exp;
        logic [7:0] d;
        int cyc;
        int r, c;
        for (int p = 0; p < 2; p++) begin
            sb.delete();
            for (int k = 0; k < 400; k++) begin
                r = k / 20; c = k % 20;
                if (p == 0) d = ((r ^ c) & 1) ? 8'hFF : 8'h00;
                else        d = 8'h5A;
                sb.push_back({k == 0, c == 19, d});
            end
            mode = (p == 0) ? 2'd2 : 2'd1;
            const_value = 8'h5A; tready = 1'b1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            mode = 2'd0;
            const_value = 8'h00;
            cyc = 0;
            while (sb.size() > 0 && cyc < 1000) begin
                if (tvalid) begin
                    exp = sb.pop_front();
                    vectors++;
                    if ({tuser, tlast, tdata} !== exp) begin
                        errors++;
                        $display("FAIL pattern%0d beat %0d: got %h want %h",
                                 p, 399 - sb.size(), {tuser, tlast, tdata}, exp);
                    end
                end
                @(negedge clk);
                cyc++;
            end
            if (sb.size() > 0) begin
                vectors++; errors++;
                $display("FAIL pattern%0d_timeout: %0d left, want 0", p, sb.size());
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_lfsr_continuous();
        logic [15:0] lf;
        logic [9:0] exp;
        int beats = 0, dones = 0, cyc = 0;
        sb.delete();
        for (int f = 0; f < 2; f++) begin
            lf = 16'hACE1;
            for (int k = 0; k < 400; k++) begin
                sb.push_back({k == 0, (k % 20) == 19, lf[7:0]});
                lf = step(lf);
            end
        end
        mode = 2'd3; continuous = 1'b1; tready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (sb.size() > 0 && cyc < 2000) begin
            if (done === 1'b1) dones++;
            vectors++;
            if (tvalid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL lfsr_gap at beat %0d: tvalid %b busy %b, want 1 1",
                         beats, tvalid, busy);
            end
            if (tvalid) begin
                if (beats == 0 || beats == 400) begin
                    vectors++;
                    if (tdata !== 8'hE1 || tuser !== 1'b1) begin
                        errors++;
                        $display("FAIL lfsr_first beat %0d: data %h user %b, want e1 1",
                                 beats, tdata, tuser);
                    end
                end
                if (beats == 1) begin
                    vectors++;
                    if (tdata !== 8'hC3) begin
                        errors++;
                        $display("FAIL lfsr_second: data %h, want c3", tdata);
                    end
                end
                exp = sb.pop_front();
                vectors++;
                if ({tuser, tlast, tdata} !== exp) begin
                    errors++;
                    $display("FAIL lfsr_beat %0d: got %h want %h",
                             beats, {tuser, tlast, tdata}, exp);
                end
                beats++;
            end
            if (beats >= 401) continuous = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (sb.size() > 0) begin
            vectors++; errors++;
            $display("FAIL lfsr_timeout: %0d left, want 0", sb.size());
        end
        repeat (3) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        vectors++;
        if (dones != 2 || busy !== 1'b0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL lfsr_end: done pulses %0d busy %b tvalid %b, want 2 0 0",
                     dones, busy, tvalid);
        end
        mode = 2'd0;
    endtask

    task automatic test_reset_mid();
        int hs = 0, cyc = 0;
        mode = 2'd0; continuous = 1'b0; tready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (hs < 50 && cyc < 500) begin
            if (tvalid && tready) hs++;
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset: tvalid %b busy %b, want 0 0", tvalid, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (tvalid !== 1'b1 || tuser !== 1'b1 || tdata !== 8'h00) begin
            errors++;
            $display("FAIL restart: v%b u%b data %h, want 1 1 00",
                     tvalid, tuser, tdata);
        end
        hs = 0;
        for (int i = 0; i < 800; i++) begin
            start = (i == 100) ? 1'b1 : 1'b0;
            if (tvalid && tready) hs++;
            @(negedge clk);
        end
        start = 1'b0;
        vectors++;
        if (hs != 400 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start: beats %0d busy %b, want 400 0", hs, busy);
        end
    endtask

    initial begin
        test_reset();
        test_gradient(1'b0);
        test_gradient(1'b1);
        test_hblank();
        test_patterns();
        test_lfsr_continuous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

endmodule
